conv_kxk_mac_seq: RTL and testbench
===================================

// Module: conv_kxk_mac_seq
// PURPOSE
//  Parametrised, weight-stationary KxK convolution MAC engine for the adapt_pim datapath.
//  Holds a loaded kernel in registers and accepts one flattened KxK input window per handshake.
//  Computes the window dot product over ceil(K*K/LANES) cycles using LANES multipliers.
//  Returns a saturated result on a valid/ready output port.
// PARAMETERS
//  K       5   kernel edge; window has K*K taps (K >= 1)
//  DW      6   bits per input-data tap
//  KW      6   bits per kernel tap
//  LANES   5   multipliers used per cycle (1..K*K)
//  OUT_W   18  result width; full precision is ACC_W = DW+KW+$clog2(K*K)+1
//  SIGNED  0   0: all operands unsigned; 1: two's-complement operands and result
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  kernel_ld  in   1          load kernel_in into the weight registers
//  kernel_in  in   K*K*KW     kernel taps; tap i is at [i*KW +: KW]
//  in_valid   in   1          window valid
//  in_ready   out  1          engine can accept a window
//  in_data    in   K*K*DW     window taps; tap i is at [i*DW +: DW]
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts the result
//  out_data   out  OUT_W      saturated sum over i of in_data[i]*kernel[i]
//  out_sat    out  1          out_data was clipped; qualified by out_valid
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE; kernel regs, accumulator and beat counter = 0.
//    - out_valid=0, out_data=0, out_sat=0, in_ready=1.
//  - NBEATS = ceil(K*K/LANES). Lanes past tap K*K-1 in the last beat contribute 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE:
//    - in_ready = ~kernel_ld.
//    - kernel_ld=1: latch kernel_in and stay in IDLE. This takes priority over a simultaneous in_valid; that window is not taken.
//    - in_valid & in_ready: capture in_data, clear the accumulator, set beat=0, go to BUSY.
//  - BUSY:
//    - Each cycle add LANES products of taps beat*LANES..beat*LANES+LANES-1 at ACC_W, sign-extended when SIGNED=1.
//    - beat increments each cycle. After beat NBEATS-1, go to DONE.
//    - in_ready=0. kernel_ld is ignored and the kernel is unchanged.
//  - DONE:
//    - out_valid=1. out_data/out_sat are registered and stable until the handshake.
//    - out_valid & out_ready: go to IDLE. out_valid drops on the next edge.
//    - in_ready=0 and kernel_ld is ignored.
//  - Latency: accept edge to out_valid high is NBEATS cycles. Minimum window period is NBEATS+2 cycles.
//  - Saturation when OUT_W < ACC_W:
//    - Unsigned: clip to 2^OUT_W-1.
//    - Signed: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    - out_sat=1 on any clip. When OUT_W >= ACC_W, the result is extended and out_sat=0.
//  - Reset during BUSY or DONE discards the window and result and clears the kernel.
//  - The in_data capture is independent of later input changes. in_data may change freely after the accept edge.
// TESTING
//  - Ones kernel: load kernel all 1, window all 63 (K=5, DW=KW=6) -> out_data=1575, out_valid 5 cycles after accept, out_sat=0.
//  - Max operands: kernel all 63, data all 63 -> out_data=99225, out_sat=0. Same stimulus with OUT_W=16 -> out_data=65535, out_sat=1.
//  - Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0. Then out_ready=1 -> IDLE; the next window is accepted 1 cycle later.
//  - Signed: SIGNED=1, data all 6'h20 (-32), kernel all 31 -> out_data=-24800 in 18 bits, out_sat=0.
//  - Priority:
//    - In IDLE, kernel_ld=1 and in_valid=1 together -> in_ready=0 and the kernel is loaded.
//    - Window accepted next cycle -> result uses the new kernel.
//    - kernel_ld pulsed in BUSY -> ignored.
//  - Lanes and reset:
//    - LANES=7 (NBEATS=4) with the ones-kernel case -> out_data=1575 after 4 cycles.
//    - rst_n low mid-BUSY -> out_valid=0 and kernel=0 immediately. After release, in_ready=1.

Source files
------------

// File: rtl/conv_kxk_mac_seq.sv
// Weight-stationary KxK convolution MAC: holds a kernel, folds one window over NBEATS cycles
// with LANES multipliers, and returns a saturated result on a valid/ready port.
module conv_kxk_mac_seq #(
   parameter int unsigned K      = 5,
   parameter int unsigned DW     = 6,
   parameter int unsigned KW     = 6,
   parameter int unsigned LANES  = 5,
   parameter int unsigned OUT_W  = 18,
   parameter int unsigned SIGNED = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                kernel_ld,
   input  logic [K*K*KW-1:0]   kernel_in,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [K*K*DW-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_sat
);
   localparam int unsigned TAPS   = K * K;
   localparam int unsigned NBEATS = (TAPS + LANES - 1) / LANES;
   localparam int unsigned ACC_W  = DW + KW + $clog2(TAPS) + 1;
   localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned TIW    = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    kernel_q [TAPS];
   logic [DW-1:0]    data_q   [TAPS];
   logic [ACC_W-1:0] acc_q, acc_next, beat_sum;
   logic [BW-1:0]    beat_q;
   logic [OUT_W-1:0] out_data_q, sat_data;
   logic             out_sat_q, sat_flag;
   logic             accept, last_beat;

   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_q == BW'(NBEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StBusy;
         StBusy:  if (last_beat) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = !kernel_ld;
         StDone:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Lanes that fall past the last tap in the final beat contribute nothing.
   always_comb begin
      logic [TIW-1:0]   tap;
      logic [ACC_W-1:0] d_ext, k_ext;
      beat_sum = '0;
      tap      = '0;
      d_ext    = '0;
      k_ext    = '0;
      for (int l = 0; l < int'(LANES); l++) begin
         if (int'(beat_q) * int'(LANES) + l < int'(TAPS)) begin
            tap      = TIW'(int'(beat_q) * int'(LANES) + l);
            d_ext    = {{(ACC_W-DW){(SIGNED != 0) && data_q[tap][DW-1]}}, data_q[tap]};
            k_ext    = {{(ACC_W-KW){(SIGNED != 0) && kernel_q[tap][KW-1]}}, kernel_q[tap]};
            beat_sum = beat_sum + d_ext * k_ext;
         end
      end
   end

   assign acc_next = acc_q + beat_sum;

   if (OUT_W >= ACC_W) begin : g_wide
      always_comb begin
         sat_flag = 1'b0;
         if (SIGNED != 0) sat_data = OUT_W'($signed(acc_next));
         else             sat_data = OUT_W'(acc_next);
      end
   end else begin : g_clip
      // Signed results fit only when every bit from OUT_W-1 upward equals the sign bit.
      always_comb begin
         sat_flag = 1'b0;
         sat_data = acc_next[OUT_W-1:0];
         if (SIGNED != 0) begin
            if (!(&acc_next[ACC_W-1:OUT_W-1]) && (|acc_next[ACC_W-1:OUT_W-1])) begin
               sat_flag = 1'b1;
               sat_data = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
            end
         end else if (|acc_next[ACC_W-1:OUT_W]) begin
            sat_flag = 1'b1;
            sat_data = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(TAPS); i++) begin
            kernel_q[i] <= '0;
            data_q[i]   <= '0;
         end
         acc_q      <= '0;
         beat_q     <= '0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (kernel_ld) begin
                  for (int i = 0; i < int'(TAPS); i++) kernel_q[i] <= kernel_in[i*KW +: KW];
               end else if (in_valid) begin
                  for (int i = 0; i < int'(TAPS); i++) data_q[i] <= in_data[i*DW +: DW];
                  acc_q  <= '0;
                  beat_q <= '0;
               end
            end
            StBusy: begin
               acc_q  <= acc_next;
               beat_q <= beat_q + BW'(1);
               if (last_beat) begin
                  out_data_q <= sat_data;
                  out_sat_q  <= sat_flag;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data = out_data_q;
   assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_conv_kxk_mac_seq.sv
// Bench for conv_kxk_mac_seq: four parameter variants share one stimulus stream; results are
// checked against an arithmetic reference through per-variant scoreboard queues.
module tb_conv_kxk_mac_seq;
   localparam int DW = 6;
   localparam int T  = 25;
   localparam int VW = 150;

   typedef struct packed {
      logic [31:0] d;
      logic        s;
   } exp_t;

   logic          clk = 1'b0, rst_n = 1'b0, kernel_ld = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [VW-1:0] kernel_in = '0, in_data = '0, kmodel = '0;
   logic [3:0]    rdy, ov, os;
   logic [17:0]   od0, od2, od3;
   logic [15:0]   od1;
   bit            hold_rdy = 1'b1;
   int            checks = 0, errors = 0;
   exp_t          q0[$], q1[$], q2[$], q3[$];
   logic [31:0]   cdat [4];
   logic          csat [4];

   always #5 clk = ~clk;

   conv_kxk_mac_seq u0 (
      .clk(clk), .rst_n(rst_n), .kernel_ld(kernel_ld), .kernel_in(kernel_in),
      .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .out_valid(ov[0]),
      .out_ready(out_ready), .out_data(od0), .out_sat(os[0]));
   conv_kxk_mac_seq #(.OUT_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .kernel_ld(kernel_ld), .kernel_in(kernel_in),
      .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .out_valid(ov[1]),
      .out_ready(out_ready), .out_data(od1), .out_sat(os[1]));
   conv_kxk_mac_seq #(.SIGNED(1)) u2 (
      .clk(clk), .rst_n(rst_n), .kernel_ld(kernel_ld), .kernel_in(kernel_in),
      .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data), .out_valid(ov[2]),
      .out_ready(out_ready), .out_data(od2), .out_sat(os[2]));
   conv_kxk_mac_seq #(.LANES(7)) u3 (
      .clk(clk), .rst_n(rst_n), .kernel_ld(kernel_ld), .kernel_in(kernel_in),
      .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data), .out_valid(ov[3]),
      .out_ready(out_ready), .out_data(od3), .out_sat(os[3]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, got, got, exp, exp, $time);
      end
   endtask

   // Variant j: 0 default, 1 OUT_W=16, 2 signed, 3 LANES=7.
   function automatic logic [31:0] model(input int j, input logic [VW-1:0] w,
                                         input logic [VW-1:0] kv, output logic sat);
      longint s = 0, d, k, lo, hi;
      int     ow = (j == 1) ? 16 : 18;
      bit     sg = (j == 2);
      for (int i = 0; i < T; i++) begin
         d = longint'(w[i*DW +: DW]);
         k = longint'(kv[i*DW +: DW]);
         if (sg) begin
            if (d >= 32) d -= 64;
            if (k >= 32) k -= 64;
         end
         s += d * k;
      end
      if (sg) begin
         lo = -(longint'(1) << (ow - 1));
         hi = (longint'(1) << (ow - 1)) - 1;
      end else begin
         lo = 0;
         hi = (longint'(1) << ow) - 1;
      end
      sat = 1'b0;
      if (s > hi) begin
         s   = hi;
         sat = 1'b1;
      end else if (s < lo) begin
         s   = lo;
         sat = 1'b1;
      end
      return 32'(s & ((longint'(1) << ow) - 1));
   endfunction

   function automatic logic [VW-1:0] fill(input logic [5:0] v);
      logic [VW-1:0] w;
      for (int i = 0; i < T; i++) w[i*DW +: DW] = v;
      return w;
   endfunction

   function automatic logic [VW-1:0] rnd_w(input bit big);
      logic [VW-1:0] w;
      for (int i = 0; i < T; i++)
         w[i*DW +: DW] = big ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 63));
      return w;
   endfunction

   task automatic push_exp(input logic [VW-1:0] w, input bit use_const);
      exp_t e;
      logic s_m;
      for (int j = 0; j < 4; j++) begin
         if (use_const) begin
            e.d = cdat[j];
            e.s = csat[j];
         end else begin
            e.d = model(j, w, kmodel, s_m);
            e.s = s_m;
         end
         case (j)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
         endcase
      end
   endtask

   task automatic pop_check(input int j, input logic [31:0] got_d, input logic got_s);
      exp_t e;
      bit   empty;
      case (j)
         0:       empty = (q0.size() == 0);
         1:       empty = (q1.size() == 0);
         2:       empty = (q2.size() == 0);
         default: empty = (q3.size() == 0);
      endcase
      if (empty) begin
         checks++;
         errors++;
         $display("FAIL dut%0d unexpected result: got %0d expected none", j, got_d);
         return;
      end
      case (j)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         2:       e = q2.pop_front();
         default: e = q3.pop_front();
      endcase
      check($sformatf("dut%0d out_data", j), got_d, e.d);
      check($sformatf("dut%0d out_sat", j), 32'(got_s), 32'(e.s));
   endtask

   // Monitor: a result is consumed on the edge following a negedge that sees valid & ready.
   always @(negedge clk) begin
      if (rst_n && out_ready) begin
         if (ov[0]) pop_check(0, 32'(od0), os[0]);
         if (ov[1]) pop_check(1, 32'(od1), os[1]);
         if (ov[2]) pop_check(2, 32'(od2), os[2]);
         if (ov[3]) pop_check(3, 32'(od3), os[3]);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!hold_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (rdy !== 4'hF && n < 200) begin
         tick();
         n++;
      end
      if (rdy !== 4'hF) begin
         checks++;
         errors++;
         $display("FAIL wait_idle timeout: in_ready=%b expected 1111", rdy);
      end
   endtask

   task automatic load_kernel(input logic [VW-1:0] k);
      wait_idle();
      kernel_ld = 1'b1;
      kernel_in = k;
      tick();
      kernel_ld = 1'b0;
      kernel_in = rnd_w(0);
      kmodel    = k;
   endtask

   task automatic send(input logic [VW-1:0] w, input bit use_const);
      wait_idle();
      in_valid = 1'b1;
      in_data  = w;
      push_exp(w, use_const);
      tick();
      in_valid = 1'b0;
      in_data  = rnd_w(0);
   endtask

   initial begin
      logic [VW-1:0] w, k2;
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(rdy), 32'hF);
      check("reset out_valid", 32'(ov), 32'h0);
      check("reset out_sat", 32'(os), 32'h0);
      check("reset out_data", 32'(|{od0, od1, od2, od3}), 32'h0);
      rst_n = 1'b1;
      tick();

      // Ones kernel, latency per variant, then backpressure in DONE.
      load_kernel(fill(6'd1));
      cdat = '{32'd1575, 32'd1575, 32'd262119, 32'd1575};
      csat = '{1'b0, 1'b0, 1'b0, 1'b0};
      send(fill(6'd63), 1'b1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 4) begin
            check("lat4 dut0 out_valid", 32'(ov[0]), 32'd0);
            check("lat4 dut3 out_valid", 32'(ov[3]), 32'd1);
            check("lat4 dut3 out_data", 32'(od3), 32'd1575);
         end
         if (c == 5) begin
            check("lat5 dut0 out_valid", 32'(ov[0]), 32'd1);
            check("lat5 dut0 out_data", 32'(od0), 32'd1575);
            check("lat5 dut0 out_sat", 32'(os[0]), 32'd0);
         end
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp out_data", 32'(od0), 32'd1575);
         check("bp out_valid", 32'(ov[0]), 32'd1);
         check("bp in_ready", 32'(rdy[0]), 32'd0);
      end
      w        = rnd_w(0);
      in_valid = 1'b1;
      in_data  = w;
      push_exp(w, 1'b0);
      out_ready = 1'b1;
      tick();
      check("handshake out_valid drop", 32'(ov), 32'h0);
      check("handshake in_ready", 32'(rdy), 32'hF);
      tick();
      check("next window accepted", 32'(rdy), 32'h0);
      in_valid = 1'b0;
      in_data  = rnd_w(0);
      hold_rdy = 1'b0;

      load_kernel(fill(6'd63));
      cdat = '{32'd99225, 32'd65535, 32'd25, 32'd99225};
      csat = '{1'b0, 1'b1, 1'b0, 1'b0};
      send(fill(6'd63), 1'b1);

      load_kernel(fill(6'd31));
      cdat = '{32'd24800, 32'd24800, 32'd237344, 32'd24800};
      csat = '{1'b0, 1'b0, 1'b0, 1'b0};
      send(fill(6'h20), 1'b1);

      // kernel_ld beats a simultaneous in_valid; a load pulse during BUSY is dropped.
      wait_idle();
      k2        = rnd_w(0);
      w         = rnd_w(0);
      kernel_ld = 1'b1;
      kernel_in = k2;
      in_valid  = 1'b1;
      in_data   = w;
      #1;
      check("prio in_ready", 32'(rdy), 32'h0);
      tick();
      kernel_ld = 1'b0;
      kmodel    = k2;
      #1;
      check("prio in_ready after load", 32'(rdy), 32'hF);
      push_exp(w, 1'b0);
      tick();
      in_valid = 1'b0;
      in_data  = rnd_w(0);
      kernel_ld = 1'b1;
      kernel_in = rnd_w(1);
      #1;
      check("busy in_ready", 32'(rdy), 32'h0);
      tick();
      kernel_ld = 1'b0;
      send(rnd_w(0), 1'b0);

      // Reset mid-BUSY drops the window and clears the kernel.
      send(rnd_w(0), 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(ov), 32'h0);
      check("midrst in_ready", 32'(rdy), 32'hF);
      check("midrst out_data", 32'(|{od0, od1, od2, od3}), 32'h0);
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
      kmodel = '0;
      tick();
      rst_n = 1'b1;
      tick();
      check("post-rst in_ready", 32'(rdy), 32'hF);
      send(rnd_w(1), 1'b0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) load_kernel(rnd_w(1'($urandom_range(0, 1))));
         send(rnd_w($urandom_range(0, 2) == 0), 1'b0);
      end

      n = 0;
      while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && n < 500) begin
         tick();
         n++;
      end
      check("drain pending results", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
